// File: rtl/cafea_brew_ctrl_pkg.sv
// rtl/cafea_brew_ctrl_pkg.sv - shared state and drink codes for the brew controller
// Purpose: state encoding (also shown on the debug display) and drink codes.
// The credit/selection FSM uses the same drink codes.
package cafea_brew_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRIND = 3'd1,
        ST_BREW  = 3'd2,
        ST_MILK  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    localparam logic [1:0] DR_NONE  = 2'b00;
    localparam logic [1:0] DR_EXPR  = 2'b01;
    localparam logic [1:0] DR_EXPRL = 2'b10;
    localparam logic [1:0] DR_CAP   = 2'b11;

endpackage

// File: rtl/cafea_phase_timer.sv
// rtl/cafea_phase_timer.sv - down-counter that times one brew phase
// Purpose: loaded with T-1 on phase entry, counts down while run=1, flags expiry at 0.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load, load_val  load the count (load wins over run)
//   run             decrement by one this cycle (held at 0 once there)
//   expired         count == 0
module cafea_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             run,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (run && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/cafea_brew_ctrl.sv
// rtl/cafea_brew_ctrl.sv - brew sequencer: grind, brew, optional milk, then done/err
// Purpose: Moore FSM driving grinder, pump and frother through timed phases.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   start, drink, water_ok, abort  request, drink code, water sensor, service abort
//   ready                          high in IDLE only
//   grinder_on, pump_on, frother_on actuator enables (at most one at a time)
//   done, err                      one-cycle completion / failure pulses
//   state                          current state code for the debug display
module cafea_brew_ctrl
    import cafea_brew_ctrl_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int T_GRIND      = 4,
    parameter int T_BREW_SHORT = 6,
    parameter int T_BREW_LONG  = 10,
    parameter int T_MILK       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] drink,
    input  logic       water_ok,
    input  logic       abort,
    output logic       ready,
    output logic       grinder_on,
    output logic       pump_on,
    output logic       frother_on,
    output logic       done,
    output logic       err,
    output logic [2:0] state
);

    localparam logic [CNT_W-1:0] LD_GRIND = CNT_W'(T_GRIND - 1);
    localparam logic [CNT_W-1:0] LD_SHORT = CNT_W'(T_BREW_SHORT - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_BREW_LONG - 1);
    localparam logic [CNT_W-1:0] LD_MILK  = CNT_W'(T_MILK - 1);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       drink_q;
    logic [1:0]       drink_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_run;
    logic             tmr_expired;

    cafea_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .run      (tmr_run),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_d      = state_q;
        drink_d      = drink_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_run      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (drink != DR_NONE)) begin
                    if (water_ok) begin
                        state_d      = ST_GRIND;
                        drink_d      = drink;
                        tmr_load     = 1'b1;
                        tmr_load_val = LD_GRIND;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_GRIND: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tmr_expired) begin
                    state_d      = ST_BREW;
                    tmr_load     = 1'b1;
                    tmr_load_val = (drink_q == DR_EXPRL) ? LD_LONG : LD_SHORT;
                end else begin
                    tmr_run = 1'b1;
                end
            end
            ST_BREW: begin
                // Abort outranks a dry tank so a service abort never reports err.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!water_ok) begin
                    state_d = ST_ERR;
                end else if (tmr_expired) begin
                    if (drink_q == DR_CAP) begin
                        state_d      = ST_MILK;
                        tmr_load     = 1'b1;
                        tmr_load_val = LD_MILK;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    tmr_run = 1'b1;
                end
            end
            ST_MILK: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tmr_expired) begin
                    state_d = ST_DONE;
                end else begin
                    tmr_run = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            drink_q <= DR_NONE;
        end else begin
            state_q <= state_d;
            drink_q <= drink_d;
        end
    end

    // Pure state decode: reset clears every actuator without waiting for a clock.
    assign ready      = (state_q == ST_IDLE);
    assign grinder_on = (state_q == ST_GRIND);
    assign pump_on    = (state_q == ST_BREW);
    assign frother_on = (state_q == ST_MILK);
    assign done       = (state_q == ST_DONE);
    assign err        = (state_q == ST_ERR);
    assign state      = state_q;

endmodule

// File: tb/tb_cafea_brew_ctrl.sv
// tb/tb_cafea_brew_ctrl.sv - self-checking bench for cafea_brew_ctrl
module tb_cafea_brew_ctrl;

    localparam int TG  = 4;
    localparam int TBS = 6;
    localparam int TBL = 10;
    localparam int TM  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] drink = 2'b00;
    logic       water_ok = 1'b1;
    logic       abort = 1'b0;
    logic       ready, grinder_on, pump_on, frother_on, done, err;
    logic [2:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    cafea_brew_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .drink      (drink),
        .water_ok   (water_ok),
        .abort      (abort),
        .ready      (ready),
        .grinder_on (grinder_on),
        .pump_on    (pump_on),
        .frother_on (frother_on),
        .done       (done),
        .err        (err),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] drink;
        logic       water;
        int         grind;
        int         pump;
        int         froth;
        int         done_c;
        int         err_c;
        int         ready_c;
    } vec_t;

    vec_t vecs[5];

    // Reference model: the remaining brew as a per-cycle plan of phase codes.
    int plan[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        int g, p, f, dc, ec, rc, ov;
        g = 0; p = 0; f = 0; dc = 0; ec = 0; rc = 0; ov = 0;
        drink = v.drink; water_ok = v.water; start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step();
            start = 1'b0;
            if (grinder_on) g++;
            if (pump_on) p++;
            if (frother_on) f++;
            if (done) dc = c;
            if (err) ec = c;
            if ((grinder_on ? 1 : 0) + (pump_on ? 1 : 0) + (frother_on ? 1 : 0) > 1) ov++;
            if (ready) begin
                rc = c;
                break;
            end
        end
        water_ok = 1'b1;
        chk({v.name, " grind_cycles"}, g, v.grind);
        chk({v.name, " pump_cycles"}, p, v.pump);
        chk({v.name, " froth_cycles"}, f, v.froth);
        chk({v.name, " done_cycle"}, dc, v.done_c);
        chk({v.name, " err_cycle"}, ec, v.err_c);
        chk({v.name, " ready_cycle"}, rc, v.ready_c);
        chk({v.name, " overlap"}, ov, 0);
    endtask

    task automatic start_brew(input logic [1:0] d);
        drink = d; water_ok = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && !ready; i++) step();
        chk({name, " back_to_idle"}, int'(ready), 1);
    endtask

    function automatic void build_plan(input logic [1:0] d);
        int brew_len;
        brew_len = (d == 2'b10) ? TBL : TBS;
        for (int i = 0; i < TG; i++) plan.push_back(1);
        for (int i = 0; i < brew_len; i++) plan.push_back(2);
        if (d == 2'b11) for (int i = 0; i < TM; i++) plan.push_back(3);
        plan.push_back(4);
    endfunction

    function automatic logic [8:0] exp_out(input int cur);
        return {cur == 0, cur == 1, cur == 2, cur == 3, cur == 4, cur == 5, 3'(cur)};
    endfunction

    initial begin
        int dc, fc;
        vecs[0] = '{"espresso", 2'b01, 1'b1, 4, 6, 0, 11, 0, 12};
        vecs[1] = '{"long",     2'b10, 1'b1, 4, 10, 0, 15, 0, 16};
        vecs[2] = '{"cappu",    2'b11, 1'b1, 4, 6, 5, 16, 0, 17};
        vecs[3] = '{"no_water", 2'b01, 1'b0, 0, 0, 0, 0, 1, 2};
        vecs[4] = '{"no_drink", 2'b00, 1'b1, 0, 0, 0, 0, 0, 1};

        // Reset state
        step();
        chk("reset_outputs", int'({ready, grinder_on, pump_on, frother_on, done, err, state}),
            int'(9'b1_00000_000));
        rst = 1'b0;
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Water drops in the third BREW cycle
        start_brew(2'b01);
        repeat (6) step();
        chk("wdrop in_brew", int'(state), 2);
        water_ok = 1'b0;
        step();
        water_ok = 1'b1;
        chk("wdrop pump", int'(pump_on), 0);
        chk("wdrop err", int'(err), 1);
        step();
        chk("wdrop idle", int'(ready), 1);

        // Abort in the second MILK cycle
        start_brew(2'b11);
        repeat (11) step();
        chk("abort_milk in_milk", int'(state), 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_milk state", int'(state), 0);
        dc = 0;
        for (int i = 0; i < 10; i++) begin
            if (done || err) dc++;
            step();
        end
        chk("abort_milk no_pulse", dc, 0);

        // Abort and dry tank together in BREW
        start_brew(2'b01);
        repeat (5) step();
        abort = 1'b1; water_ok = 1'b0;
        step();
        abort = 1'b0; water_ok = 1'b1;
        chk("abort_wet state", int'(state), 0);
        chk("abort_wet err", int'(err), 0);
        step();
        chk("abort_wet err_late", int'(err), 0);

        // Drink code changes mid-GRIND
        start_brew(2'b01);
        step();
        drink = 2'b11;
        dc = 0; fc = 0;
        for (int c = 3; c <= 30; c++) begin
            step();
            if (frother_on) fc++;
            if (done) dc = c;
            if (ready) break;
        end
        chk("mid_change done_cycle", dc, 11);
        chk("mid_change froth", fc, 0);

        // start held high: one IDLE cycle between brews
        drink = 2'b01; water_ok = 1'b1; start = 1'b1;
        step();
        repeat (10) step();
        chk("held cyc11", int'(state), 4);
        step();
        chk("held cyc12", int'(state), 0);
        step();
        chk("held cyc13", int'(state), 1);
        start = 1'b0;
        drain("held");

        // Asynchronous reset mid-BREW
        start_brew(2'b01);
        repeat (5) step();
        #2 rst = 1'b1;
        #1 chk("async_rst outputs", int'({ready, grinder_on, pump_on, frother_on, done, err, state}),
               int'(9'b1_00000_000));
        @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[0]);

        // Randomized run against the plan model
        rst = 1'b1;
        step();
        rst = 1'b0;
        plan.delete();
        for (int i = 0; i < 3000; i++) begin
            int cur;
            logic [8:0] act, exp;
            cur = (plan.size() == 0) ? 0 : plan[0];
            act = {ready, grinder_on, pump_on, frother_on, done, err, state};
            exp = exp_out(cur);
            n_checks++;
            if (act == exp) n_pass++;
            else $display("FAIL rand cyc %0d: got %b expected %b", i, act, exp);

            start    = ($urandom_range(0, 3) == 0);
            drink    = 2'($urandom_range(0, 3));
            water_ok = ($urandom_range(0, 15) != 0);
            abort    = ($urandom_range(0, 31) == 0);

            if (cur == 0) begin
                if (start && drink != 2'b00) begin
                    if (water_ok) build_plan(drink);
                    else plan.push_back(5);
                end
            end else if (abort && cur >= 1 && cur <= 3) begin
                plan.delete();
            end else if (cur == 2 && !water_ok) begin
                plan.delete();
                plan.push_back(5);
            end else begin
                void'(plan.pop_front());
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
